// File: rtl/door_servo_sequencer_if.sv
// rtl/door_servo_sequencer_if.sv - front-panel/mode inputs and servo/status outputs of the door sequencer
interface door_servo_sequencer_if;
    logic [4:0] rise_button;
    logic [1:0] state;
    logic       force_close;
    logic       servo;
    logic       door_open;
    logic       moving;
    logic [1:0] door_history;

    modport master (
        output rise_button, state, force_close,
        input  servo, door_open, moving, door_history
    );

    modport slave (
        input  rise_button, state, force_close,
        output servo, door_open, moving, door_history
    );
endinterface

// File: rtl/door_servo_sequencer.sv
// rtl/door_servo_sequencer.sv - door servo sequencer with ramped 50 Hz PWM; DOOR_AUTO_CLOSE_EN builds the auto-close timer
module door_servo_sequencer #(
    parameter int FRAME_CYC         = 1_000_000,
    parameter int OPEN_HT           = 75_000,
    parameter int CLOSE_HT          = 170_000,
    parameter int STEP              = 5_000,
    parameter int AUTO_CLOSE_FRAMES = 250
) (
    input  logic                 clk,
    input  logic                 reset,
    door_servo_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(FRAME_CYC);
    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0] OPEN_V  = CNT_W'(OPEN_HT);
    localparam logic [CNT_W-1:0] CLOSE_V = CNT_W'(CLOSE_HT);
    localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(STEP);

    if (CLOSE_HT <= OPEN_HT || ((CLOSE_HT - OPEN_HT) % STEP) != 0 ||
        CLOSE_HT >= FRAME_CYC || AUTO_CLOSE_FRAMES < 1) begin : g_bad_cfg
        $error("door_servo_sequencer: inconsistent parameter set");
    end

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } door_state_e;

    door_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ht_q, ht_d;
    logic [1:0]       hist_q, hist_d;
    logic             servo_q, servo_d;

    logic             boundary;
    logic             toggle;
    logic             auto_hit;
    logic             close_req;
    logic             target_d;
    logic [CNT_W-1:0] ht_down;
    logic [CNT_W-1:0] ht_up;
    logic             unused_buttons;

    assign unused_buttons = ^{bus.rise_button[4:2], bus.rise_button[0]};

    assign boundary  = (cnt_q == LAST_V);
    assign toggle    = bus.rise_button[1] && (bus.state == 2'b01);
    assign close_req = bus.force_close || auto_hit ||
                       ((bus.state != 2'b01) && hist_q[0]);

    // Saturating steps written to avoid any wrap of the compare operands.
    assign ht_down = (ht_q >= OPEN_V + STEP_V)  ? ht_q - STEP_V : OPEN_V;
    assign ht_up   = (ht_q <= CLOSE_V - STEP_V) ? ht_q + STEP_V : CLOSE_V;

`ifdef DOOR_AUTO_CLOSE_EN
    localparam int AC_W = $clog2(AUTO_CLOSE_FRAMES + 1);
    localparam logic [AC_W-1:0] AC_LIM = AC_W'(AUTO_CLOSE_FRAMES);

    logic [AC_W-1:0] auto_cnt_q, auto_cnt_d;

    assign auto_hit = (state_q == ST_OPEN) && (auto_cnt_q == AC_LIM);

    // Held at zero outside OPEN, so every entry into OPEN starts a fresh count.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (state_q != ST_OPEN) begin
            auto_cnt_d = '0;
        end else if (boundary && !auto_hit) begin
            auto_cnt_d = auto_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        cnt_d = boundary ? '0 : cnt_q + 1'b1;
        servo_d = (cnt_q < ht_q);
    end

    // The ramp step follows the direction held before this cycle's command.
    always_comb begin
        state_d = state_q;
        ht_d    = ht_q;

        if (boundary) begin
            case (state_q)
                ST_OPENING: ht_d = ht_down;
                ST_CLOSING: ht_d = ht_up;
                default:    ht_d = ht_q;
            endcase
        end

        case (state_q)
            ST_CLOSED: begin
                if (toggle && !bus.force_close) state_d = ST_OPENING;
            end
            ST_OPENING: begin
                if (toggle || close_req)               state_d = ST_CLOSING;
                else if (boundary && ht_down == OPEN_V) state_d = ST_OPEN;
            end
            ST_OPEN: begin
                if (toggle || close_req) state_d = ST_CLOSING;
            end
            ST_CLOSING: begin
                if (toggle && !bus.force_close)        state_d = ST_OPENING;
                else if (boundary && ht_up == CLOSE_V) state_d = ST_CLOSED;
            end
            default: state_d = ST_CLOSED;
        endcase
    end

    always_comb begin
        target_d = (state_d == ST_OPENING) || (state_d == ST_OPEN);
        hist_d   = hist_q;
        if (target_d != hist_q[0]) begin
            hist_d = {hist_q[0], target_d};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLOSED;
            cnt_q   <= '0;
            ht_q    <= CLOSE_V;
            hist_q  <= 2'b00;
            servo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ht_q    <= ht_d;
            hist_q  <= hist_d;
            servo_q <= servo_d;
        end
    end

    assign bus.servo        = servo_q;
    assign bus.door_open    = (state_q == ST_OPEN);
    assign bus.moving       = (state_q == ST_OPENING) || (state_q == ST_CLOSING);
    assign bus.door_history = hist_q;

endmodule

// File: doc/door_servo_sequencer.md
Name: door_servo_sequencer

Overview:
- Controls the door servo for the appliance.
- Accepts door open/close requests from the front-panel button (microwave mode only), a forced-close input and an auto-close timer.
- Ramps the servo pulse width one step per 20 ms PWM frame, so the door moves smoothly instead of jumping.
- Generates the 50 Hz servo PWM and reports door status and command history to the display/state logic.

Parameters:
- FRAME_CYC, 1_000_000: clocks per PWM frame (20 ms at 50 MHz).
- OPEN_HT, 75_000: pulse high time for the fully-open position.
- CLOSE_HT, 170_000: pulse high time for the fully-closed position. Must be greater than OPEN_HT.
- STEP, 5_000: high-time change per frame while moving. (CLOSE_HT-OPEN_HT) must be a multiple of STEP.
- AUTO_CLOSE_FRAMES, 250: frames spent in OPEN before auto-close (5 s).

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- rise_button  in  5  one-cycle button rise pulses; bit 1 = door toggle
- state  in  2  system mode; 2'b01 = MICROWAVE
- force_close  in  1  level; requests a close, e.g. when cooking starts
- servo  out  1  registered PWM output
- door_open  out  1  1 only in the OPEN state
- moving  out  1  1 in OPENING or CLOSING
- door_history  out  2  [0] = current commanded target (1 = open), [1] = previous target

Behaviour:
- Reset values: FSM = CLOSED, frame cnt = 0, high_time = CLOSE_HT, auto-close counter = 0, servo = 0, door_open = 0, moving = 0, door_history = 2'b00.
- Frame counter:
  - cnt counts 0..FRAME_CYC-1, then wraps to 0.
  - The wrap cycle (cnt == FRAME_CYC-1) is the "frame boundary".
- PWM: servo <= (cnt < high_time), registered, so servo lags cnt by one clock.
- high_time changes only at a frame boundary, so there is never a mid-frame glitch.
- toggle = rise_button[1] && state == 2'b01. A toggle is ignored in any other mode.
- close_req is asserted by any of: force_close; the auto-close counter reaching its limit; state != 2'b01 while the target is open.
- FSM states: CLOSED, OPENING, OPEN, CLOSING.
- Transitions (registered; take effect the cycle after the event):
  - CLOSED: toggle and !force_close -> OPENING. close_req has no effect.
  - OPENING: toggle or close_req -> CLOSING (reverses mid-travel). At a boundary, high_time -= STEP, saturating at OPEN_HT. On reaching OPEN_HT -> OPEN in the same cycle.
  - OPEN: toggle or close_req -> CLOSING.
  - CLOSING: toggle and !force_close -> OPENING. At a boundary, high_time += STEP, saturating at CLOSE_HT. On reaching CLOSE_HT -> CLOSED.
- Priority: force_close beats toggle. A toggle in the same cycle as force_close is dropped, not queued.
- Command coincident with a frame boundary: the step uses the pre-update direction. The new direction applies from the next boundary.
- door_history updates only when the target changes: [1] <= [0], [0] <= new target. Repeated close requests while the target is already closed leave it unchanged.
- Auto-close counter:
  - Cleared on entering OPEN; increments at each boundary while in OPEN.
  - At AUTO_CLOSE_FRAMES it asserts close_req for one cycle and holds until OPEN is left.
- Full travel takes (CLOSE_HT-OPEN_HT)/STEP frames; defaults give 19 frames (380 ms).
- Reset mid-motion: immediate return to reset values. The door command is re-driven to closed on the next frame.

Optional Feature:
- Macro DOOR_AUTO_CLOSE_EN.
- Defined: the auto-close counter and the auto-close term of close_req exist as described above.
- Undefined: no auto-close counter is built. OPEN persists until a toggle, force_close or a mode change.

Test Plan (bench parameters: FRAME_CYC=2000, OPEN_HT=100, CLOSE_HT=200, STEP=25, AUTO_CLOSE_FRAMES=3):
- After reset release -> servo high for exactly 200 clocks per 2000-clock frame; door_history=00; moving=0.
- toggle pulse in MICROWAVE -> moving=1 next cycle. high_time sequence 175/150/125/100 over the next 4 boundaries. door_open=1 at the 4th boundary; door_history=01.
- toggle during OPENING after the 2nd boundary (high_time=150) -> CLOSING. Next boundaries give 175, 200 -> CLOSED; door_history=10.
- toggle and force_close in the same cycle while CLOSED -> no motion, door_history unchanged.
- In OPEN with DOOR_AUTO_CLOSE_EN defined -> CLOSING starts 3 frames later. With the macro undefined, still OPEN after 10 frames.
- In OPEN, state changes to 2'b10 -> CLOSING the next cycle. Toggles are ignored until state returns to 2'b01. reset asserted mid-ramp -> servo=0 and high_time=200 immediately.
